background_fetch: RTL and testbench

- Upstream stage of the background palette lookup. Turns the VGA controller's drawX/drawY into a background ROM address, with frame-synchronous horizontal scroll and wrap-around.
- Returns the 4-bit palette index read from the ROM, together with sync and valid signals delayed by the same number of cycles.
- Sits between the VGA controller and the background ROM on one side, and the palette lookup and colour mapper on the other.

---
 rtl/background_fetch.sv | 99 +++++++++
 tb/tb_background_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/background_fetch.sv
// Background fetch: maps drawX/drawY plus a per-frame horizontal scroll onto a background ROM address and aligns the
// returned palette index with delayed sync/valid. Optional transparent-key flag is built when BG_KEY_EN is defined.
module background_fetch #(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int ROM_LAT     = 1
`ifdef BG_KEY_EN
  , parameter int KEY_IDX   = 0
`endif
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic [9:0]        drawX,
  input  logic [9:0]        drawY,
  input  logic              active_nblank,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              scroll_en,
  input  logic [3:0]        scroll_step,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        index,
  output logic              pix_valid,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              key_hit
);

  localparam int CW = 11;
  localparam logic [CW-1:0] IMG_W_C = CW'(IMG_W);
  localparam logic [CW-1:0] IMG_H_C = CW'(IMG_H);

  logic              vsync_prev_q;
  logic [CW-1:0]     x_off_q, x_off_d, x_sum;
  logic              frame_start;
  logic [CW-1:0]     sx_raw, sx, sy;
  logic              in_img;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0]  valid_q, hs_q, vs_q;
  logic              unused_bits;

  assign unused_bits = ^{drawX, drawY};

  // Scroll offset only moves on the falling edge of vsync so a frame is never torn.
  always_comb begin
    frame_start = vsync_prev_q & ~vsync_in;
    x_sum       = x_off_q + CW'(scroll_step);
    x_off_d     = x_off_q;
    if (frame_start && scroll_en) begin
      x_off_d = (x_sum >= IMG_W_C) ? (x_sum - IMG_W_C) : x_sum;
    end
  end

  // Stage 0 uses the pre-update x_off, so a forced frame_start on a visible pixel sees the old offset.
  always_comb begin
    sx_raw     = CW'(drawX >> SCALE_SHIFT) + x_off_q;
    sx         = (sx_raw >= IMG_W_C) ? (sx_raw - IMG_W_C) : sx_raw;
    sy         = CW'(drawY >> SCALE_SHIFT);
    in_img     = active_nblank && (sy < IMG_H_C);
    rom_addr_d = rom_addr_q;
    if (in_img) begin
      rom_addr_d = ADDR_W'(sy) * ADDR_W'(IMG_W) + ADDR_W'(sx);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      vsync_prev_q <= 1'b1;
      x_off_q      <= '0;
      rom_addr_q   <= '0;
      valid_q      <= '0;
      hs_q         <= '1;
      vs_q         <= '1;
    end else begin
      vsync_prev_q <= vsync_in;
      x_off_q      <= x_off_d;
      rom_addr_q   <= rom_addr_d;
      valid_q      <= {valid_q[ROM_LAT-1:0], in_img};
      hs_q         <= {hs_q[ROM_LAT-1:0], hsync_in};
      vs_q         <= {vs_q[ROM_LAT-1:0], vsync_in};
    end
  end

  // pix_valid qualifies index on the same cycle; there is no backpressure, every valid cycle is consumed.
  assign rom_addr  = rom_addr_q;
  assign pix_valid = valid_q[ROM_LAT];
  assign index     = pix_valid ? rom_q : 4'd0;
  assign hsync_out = hs_q[ROM_LAT];
  assign vsync_out = vs_q[ROM_LAT];

`ifdef BG_KEY_EN
  assign key_hit = pix_valid && (index == 4'(KEY_IDX));
`else
  assign key_hit = 1'b0;
`endif

endmodule

// File: tb/tb_background_fetch.sv
// Bench for background_fetch: directed scroll/wrap cases plus random pixels checked against a behavioural model
// with a modelled 1-cycle ROM. key_hit expectation follows BG_KEY_EN.
module tb_background_fetch;

  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int LAT   = 1;
  localparam int NPIX  = IMG_W * IMG_H;

  logic        pixel_clk = 1'b0;
  logic        reset;
  logic [9:0]  drawX, drawY;
  logic        active_nblank, hsync_in, vsync_in, scroll_en;
  logic [3:0]  scroll_step;
  logic [16:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  index;
  logic        pix_valid, hsync_out, vsync_out, key_hit;

  logic [3:0]  rom_mem [NPIX];

  int n_checks = 0;
  int n_pass   = 0;

  // Expected output records {key, vs, hs, valid, idx}
  logic [7:0]  exp_q[$];
  int          x_off_ref;
  logic        vprev_ref;
  int          addr_ref;

  background_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_SHIFT(1), .ADDR_W(17), .ROM_LAT(LAT)) dut (
    .pixel_clk    (pixel_clk),
    .reset        (reset),
    .drawX        (drawX),
    .drawY        (drawY),
    .active_nblank(active_nblank),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .scroll_en    (scroll_en),
    .scroll_step  (scroll_step),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .index        (index),
    .pix_valid    (pix_valid),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .key_hit      (key_hit)
  );

  // clock / ROM model
  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) begin
    rom_q <= (int'(rom_addr) < NPIX) ? rom_mem[rom_addr] : 4'd0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic set_idle();
    drawX = 10'd0; drawY = 10'd0; active_nblank = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
  endtask

  // One clock: update the model from the current inputs, clock, then compare outputs.
  task automatic step();
    int sx, sy;
    logic in_img, key;
    logic [3:0] idx;
    logic [7:0] e;
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i <= LAT; i++) exp_q.push_back(8'b0110_0000);
      x_off_ref = 0;
      vprev_ref = 1'b1;
      addr_ref  = 0;
    end else begin
      sy     = int'(drawY) / 2;
      sx     = (int'(drawX) / 2 + x_off_ref) % IMG_W;
      in_img = active_nblank && (sy < IMG_H);
      if (in_img) addr_ref = sy * IMG_W + sx;
      idx = in_img ? rom_mem[sy * IMG_W + sx] : 4'd0;
`ifdef BG_KEY_EN
      key = in_img && (idx == 4'd0);
`else
      key = 1'b0;
`endif
      exp_q.push_back({key, vsync_in, hsync_in, in_img, idx});
      if (vprev_ref && !vsync_in && scroll_en) x_off_ref = (x_off_ref + int'(scroll_step)) % IMG_W;
      vprev_ref = vsync_in;
    end
    @(posedge pixel_clk);
    #1;
    check_eq("rom_addr", 32'(rom_addr), 32'(addr_ref));
    if (exp_q.size() > LAT) begin
      e = exp_q.pop_front();
      check_eq("index",     32'(index),     32'(e[3:0]));
      check_eq("pix_valid", 32'(pix_valid), 32'(e[4]));
      check_eq("hsync_out", 32'(hsync_out), 32'(e[5]));
      check_eq("vsync_out", 32'(vsync_out), 32'(e[6]));
      check_eq("key_hit",   32'(key_hit),   32'(e[7]));
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle(); vsync_in = 1'b0; step();
      set_idle(); step();
    end
  endtask

  task automatic pixel(input int x, input int y);
    set_idle(); drawX = 10'(x); drawY = 10'(y); active_nblank = 1'b1; step();
    set_idle();
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    rom_mem[0]   = 4'd0;
    rom_mem[645] = 4'd9;
    set_idle();
    scroll_en = 1'b0; scroll_step = 4'd0;

    // Reset then idle
    reset = 1'b1; step(); step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("reset_addr", 32'(rom_addr), 32'd0);

    // First pixel at x_off=0
    pixel(10, 4);
    check_eq("addr_645", 32'(rom_addr), 32'd645);
    step();
    check_eq("idx_645", 32'(index), 32'd9);
    check_eq("valid_645", 32'(pix_valid), 32'd1);
    step();

    // Build x_off=318, then wrap
    scroll_en = 1'b1; scroll_step = 4'd6;
    frames(53);
    pixel(6, 0);
    check_eq("wrap_addr", 32'(rom_addr), 32'd1);
    step();
    scroll_step = 4'd5;
    frames(1);
    pixel(0, 0);
    check_eq("scroll_318_5", 32'(rom_addr), 32'd3);
    step();
    scroll_en = 1'b0; scroll_step = 4'd9;
    frames(2);
    pixel(0, 0);
    check_eq("scroll_hold", 32'(rom_addr), 32'd3);
    step();

    // Out of image rows and blanking, hsync still delayed
    set_idle(); drawX = 10'd20; drawY = 10'd480; active_nblank = 1'b1; hsync_in = 1'b0; step();
    set_idle(); drawX = 10'd20; drawY = 10'd4; hsync_in = 1'b0; step();
    check_eq("oob_valid", 32'(pix_valid), 32'd0);
    check_eq("oob_hsync", 32'(hsync_out), 32'd0);
    set_idle(); step(); step();

    // Key texel at address 0 after reset (x_off=0)
    reset = 1'b1; step();
    reset = 1'b0; step();
    pixel(0, 0);
    step();
`ifdef BG_KEY_EN
    check_eq("key_on", 32'(key_hit), 32'd1);
`else
    check_eq("key_off", 32'(key_hit), 32'd0);
`endif
    step();

    // Random traffic with a mid-frame reset
    for (int c = 0; c < 1500; c++) begin
      drawX         = 10'($urandom_range(0, 799));
      drawY         = 10'($urandom_range(0, 524));
      active_nblank = (drawX < 10'd640) && ($urandom_range(0, 3) != 0);
      hsync_in      = 1'($urandom_range(0, 1));
      vsync_in      = ($urandom_range(0, 15) != 0);
      scroll_en     = 1'($urandom_range(0, 1));
      scroll_step   = 4'($urandom_range(0, 15));
      reset         = 1'b0;
      if (c == 700 || c == 701) begin
        reset = 1'b1; vsync_in = 1'b1;
      end
      if (c == 702) vsync_in = 1'b1;
      step();
    end
    reset = 1'b0;
    set_idle();
    for (int i = 0; i < 3; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
